nor_chain_tester: RTL and testbench

//   Self-test sequencer around the 3-stage NOR chain (e=~(a|b), f=~(c|e), g=~(d|f)).

---
 rtl/nor_chain_tester.sv | 141 ++++++++++++++
 tb/tb_nor_chain_tester.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nor_chain_tester.sv
// Self-test sequencer for a 3-stage NOR chain: sweeps all 16 input vectors,
// checks e/f/g against a golden model after a settle window, and reports results.
module nor_chain_tester #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    output logic             dut_c,
    output logic             dut_d,
    input  logic             dut_e,
    input  logic             dut_f,
    input  logic             dut_g,
    output logic [3:0]       vec,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [3:0]       first_fail_vec,
    output logic             fail_seen,
    output logic [2:0]       miss_bits
);

    localparam int unsigned SCNT_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            state_q;
    logic [SCNT_W-1:0] settle_cnt_q;
    logic [3:0]        vec_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [CNT_W-1:0]  err_count_q;
    logic [3:0]        first_fail_vec_q;
    logic              fail_seen_q;
    logic [2:0]        miss_bits_q;

    logic              ge;
    logic              gf;
    logic              gg;
    logic [2:0]        miss_d;

    // Golden chain evaluated from the vector currently driven
    always_comb begin
        ge     = ~(vec_q[3] | vec_q[2]);
        gf     = ~(vec_q[1] | ge);
        gg     = ~(vec_q[0] | gf);
        miss_d = {dut_e ^ ge, dut_f ^ gf, dut_g ^ gg};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            settle_cnt_q     <= '0;
            vec_q            <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_count_q      <= '0;
            first_fail_vec_q <= '0;
            fail_seen_q      <= 1'b0;
            miss_bits_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q          <= S_DRIVE;
                        busy_q           <= 1'b1;
                        vec_q            <= '0;
                        err_count_q      <= '0;
                        fail_seen_q      <= 1'b0;
                        first_fail_vec_q <= '0;
                        miss_bits_q      <= '0;
                        pass_q           <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    settle_cnt_q <= SCNT_W'(SETTLE_LOAD);
                    state_q      <= (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt_q == '0) begin
                        state_q <= S_CHECK;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - SCNT_W'(1);
                    end
                end
                S_CHECK: begin
                    miss_bits_q <= miss_d;
                    if (|miss_d) begin
                        err_count_q <= err_count_q + CNT_W'(1);
                        if (!fail_seen_q) begin
                            first_fail_vec_q <= vec_q;
                            fail_seen_q      <= 1'b1;
                        end
                    end
                    if (vec_q == 4'hF) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        vec_q   <= vec_q + 4'd1;
                        state_q <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    // err_count already includes the final vector here
                    pass_q  <= (err_count_q == '0);
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dut_a          = vec_q[3];
    assign dut_b          = vec_q[2];
    assign dut_c          = vec_q[1];
    assign dut_d          = vec_q[0];
    assign vec            = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_fail_vec = first_fail_vec_q;
    assign fail_seen      = fail_seen_q;
    assign miss_bits      = miss_bits_q;

endmodule

// File: tb/tb_nor_chain_tester.sv
// Bench for nor_chain_tester: a behavioural NOR chain with injectable faults
// feeds two sequencers (default settle and zero settle); results go through a scoreboard.
module tb_nor_chain_tester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a;
    logic start_b;
    int   fault_mode;
    bit   sel;

    int checks;
    int failures;

    typedef struct {
        int         errs;
        logic [3:0] first;
        logic       fail;
        logic       pass;
    } res_t;

    res_t       res_q[$];
    logic [2:0] miss_q[$];

    // Chain under test; mode 1 = g stuck at 0, mode 2 = all outputs inverted
    function automatic logic [2:0] chain_model(input logic [3:0] v, input int mode);
        logic e, f, g;
        e = ~(v[3] | v[2]);
        f = ~(v[1] | e);
        g = ~(v[0] | f);
        case (mode)
            1:       return {e, f, 1'b0};
            2:       return ~{e, f, g};
            default: return {e, f, g};
        endcase
    endfunction

    logic       a_a, a_b, a_c, a_d, a_e, a_f, a_g;
    logic [3:0] a_vec, a_ffv;
    logic       a_busy, a_done, a_pass, a_fail;
    logic [4:0] a_err;
    logic [2:0] a_miss;

    logic       b_a, b_b, b_c, b_d, b_e, b_f, b_g;
    logic [3:0] b_vec, b_ffv;
    logic       b_busy, b_done, b_pass, b_fail;
    logic [4:0] b_err;
    logic [2:0] b_miss;

    assign {a_e, a_f, a_g} = chain_model({a_a, a_b, a_c, a_d}, fault_mode);
    assign {b_e, b_f, b_g} = chain_model({b_a, b_b, b_c, b_d}, fault_mode);

    nor_chain_tester #(.SETTLE_CYCLES(2), .CNT_W(5)) u_dut (
        .clk(clk), .rst(rst), .start(start_a),
        .dut_a(a_a), .dut_b(a_b), .dut_c(a_c), .dut_d(a_d),
        .dut_e(a_e), .dut_f(a_f), .dut_g(a_g),
        .vec(a_vec), .busy(a_busy), .done(a_done), .pass(a_pass),
        .err_count(a_err), .first_fail_vec(a_ffv), .fail_seen(a_fail),
        .miss_bits(a_miss)
    );

    nor_chain_tester #(.SETTLE_CYCLES(0), .CNT_W(5)) u_dut_s0 (
        .clk(clk), .rst(rst), .start(start_b),
        .dut_a(b_a), .dut_b(b_b), .dut_c(b_c), .dut_d(b_d),
        .dut_e(b_e), .dut_f(b_f), .dut_g(b_g),
        .vec(b_vec), .busy(b_busy), .done(b_done), .pass(b_pass),
        .err_count(b_err), .first_fail_vec(b_ffv), .fail_seen(b_fail),
        .miss_bits(b_miss)
    );

    logic [3:0]  m_stim, m_vec, m_ffv;
    logic        m_busy, m_done, m_pass, m_fail;
    logic [4:0]  m_err;
    logic [2:0]  m_miss;
    logic [23:0] m_all;

    always_comb begin
        if (sel) begin
            m_stim = {b_a, b_b, b_c, b_d}; m_vec = b_vec; m_ffv = b_ffv;
            m_busy = b_busy; m_done = b_done; m_pass = b_pass; m_fail = b_fail;
            m_err = b_err; m_miss = b_miss;
        end else begin
            m_stim = {a_a, a_b, a_c, a_d}; m_vec = a_vec; m_ffv = a_ffv;
            m_busy = a_busy; m_done = a_done; m_pass = a_pass; m_fail = a_fail;
            m_err = a_err; m_miss = a_miss;
        end
        m_all = {m_stim, m_vec, m_busy, m_done, m_pass, m_err, m_ffv, m_fail, m_miss};
    end

    task automatic set_start(input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    // Push the expected per-vector miss masks and final summary for one sweep
    task automatic push_expected(input int mode);
        res_t       r;
        logic [3:0] v;
        logic [2:0] m;
        r.errs = 0; r.first = 4'd0; r.fail = 1'b0;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            m = chain_model(v, 0) ^ chain_model(v, mode);
            miss_q.push_back(m);
            if (m != 3'b000) begin
                if (!r.fail) begin
                    r.first = v;
                    r.fail  = 1'b1;
                end
                r.errs++;
            end
        end
        r.pass = (r.errs == 0);
        res_q.push_back(r);
    endtask

    task automatic run_sweep(input int mode, input bit poke, input string name);
        int         s_len;
        int         sweep_len;
        int         done_cnt;
        res_t       r;
        logic [2:0] exp_miss;
        s_len      = sel ? 2 : 4;
        sweep_len  = 16 * s_len;
        done_cnt   = 0;
        fault_mode = mode;
        push_expected(mode);
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        for (int cyc = 0; cyc <= sweep_len + 3; cyc++) begin
            if (cyc > 0) @(negedge clk);
            set_start(1'b0);
            checks++;
            if (m_busy !== (cyc < sweep_len)) begin
                failures++;
                $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, cyc, m_busy, cyc < sweep_len);
            end
            checks++;
            if (m_done !== (cyc == sweep_len)) begin
                failures++;
                $display("FAIL %s done cyc=%0d got=%b exp=%b", name, cyc, m_done, cyc == sweep_len);
            end
            if (m_done === 1'b1) done_cnt++;
            if (cyc < sweep_len) begin
                checks++;
                if (m_vec !== 4'(cyc / s_len) || m_stim !== 4'(cyc / s_len)) begin
                    failures++;
                    $display("FAIL %s vec cyc=%0d got vec=%0d stim=%0d exp=%0d",
                             name, cyc, m_vec, m_stim, cyc / s_len);
                end
            end
            if (cyc > 0 && cyc <= sweep_len && (cyc % s_len) == 0) begin
                exp_miss = miss_q.pop_front();
                checks++;
                if (m_miss !== exp_miss) begin
                    failures++;
                    $display("FAIL %s miss_bits vec=%0d got=%b exp=%b",
                             name, cyc / s_len - 1, m_miss, exp_miss);
                end
            end
            if (poke && (cyc == 5 || cyc == sweep_len)) set_start(1'b1);
        end
        set_start(1'b0);
        r = res_q.pop_front();
        checks++;
        if (m_err !== 5'(r.errs)) begin
            failures++;
            $display("FAIL %s err_count got=%0d exp=%0d", name, m_err, r.errs);
        end
        checks++;
        if (m_fail !== r.fail || m_ffv !== r.first) begin
            failures++;
            $display("FAIL %s first_fail got seen=%b vec=%0d exp seen=%b vec=%0d",
                     name, m_fail, m_ffv, r.fail, r.first);
        end
        checks++;
        if (m_pass !== r.pass) begin
            failures++;
            $display("FAIL %s pass got=%b exp=%b", name, m_pass, r.pass);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL %s done_count got=%0d exp=1", name, done_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            @(negedge clk);
            checks++;
            if (m_all !== 24'd0) begin
                failures++;
                $display("FAIL reset_state dut=%0d got=%h exp=0", s, m_all);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_correct();
        sel = 1'b0;
        run_sweep(0, 1'b0, "correct");
    endtask

    task automatic test_stuck_g();
        sel = 1'b0;
        run_sweep(1, 1'b0, "stuck_g");
    endtask

    task automatic test_inverted();
        sel = 1'b0;
        run_sweep(2, 1'b0, "inverted");
    endtask

    task automatic test_reset_mid();
        int waited;
        sel = 1'b0;
        fault_mode = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        waited = 0;
        while (a_vec !== 4'd7 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (a_vec !== 4'd7) begin
            failures++;
            $display("FAIL reset_mid reach_vec7 got=%0d exp=7", a_vec);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (m_all !== 24'd0) begin
            failures++;
            $display("FAIL reset_mid outputs got=%h exp=0", m_all);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (a_done !== 1'b0 || a_busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid idle cyc=%0d got done=%b busy=%b exp 0 0", i, a_done, a_busy);
            end
        end
        run_sweep(0, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        run_sweep(1, 1'b1, "ignored_start_1");
        run_sweep(0, 1'b1, "ignored_start_2");
    endtask

    task automatic test_settle_zero();
        sel = 1'b1;
        run_sweep(0, 1'b0, "settle0_correct");
        run_sweep(1, 1'b0, "settle0_stuck_g");
        sel = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        start_a    = 1'b0;
        start_b    = 1'b0;
        fault_mode = 0;
        sel        = 1'b0;
        test_reset();
        test_correct();
        test_stuck_g();
        test_inverted();
        test_reset_mid();
        test_back_to_back();
        test_settle_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
